// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: one shared instruction/data memory port with a req/ready
// handshake, internal 32-entry register file, ALU and a Moore control FSM.
module mips_multicycle_core #(
    parameter int              XLEN     = 32,
    parameter int              ADDR_W   = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready,
    output logic [XLEN-1:0]   pc,
    output logic              retire,
    output logic              halted
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEMADR, S_MEMRD, S_MEMWR,
        S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_BEQ = 6'h04,
                           OP_ADDI  = 6'h08, OP_LW = 6'h23, OP_SW  = 6'h2B;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] rf_q [32];

    logic            rf_we;
    logic [4:0]      rf_wa;
    logic [XLEN-1:0] rf_wd;

    logic [5:0]      op, funct;
    logic [4:0]      rs, rt, rd;
    logic [XLEN-1:0] imm_sext, r_res, addr_full;
    logic            funct_ok, xfer, unused_shamt;

    assign op           = ir_q[31:26];
    assign rs           = ir_q[25:21];
    assign rt           = ir_q[20:16];
    assign rd           = ir_q[15:11];
    assign funct        = ir_q[5:0];
    assign imm_sext     = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
    assign unused_shamt = ^ir_q[10:6];

    always_comb begin
        r_res    = '0;
        funct_ok = 1'b1;
        case (funct)
            6'h20:   r_res = a_q + b_q;
            6'h22:   r_res = a_q - b_q;
            6'h24:   r_res = a_q & b_q;
            6'h25:   r_res = a_q | b_q;
            6'h2A:   r_res = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            default: funct_ok = 1'b0;
        endcase
    end

    // Request is a pure decode of state, gated by reset so it drops at once.
    assign mem_req   = ~reset & (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR);
    assign mem_we    = (state_q == S_MEMWR);
    assign addr_full = (state_q == S_FETCH) ? pc_q : alu_q;
    assign mem_addr  = addr_full[ADDR_W-1:0];
    assign mem_wdata = b_q;
    assign xfer      = mem_req & mem_ready;
    assign pc        = pc_q;
    assign halted    = (state_q == S_HALT);
    assign retire    = (state_q == S_ALUWB) || (state_q == S_MEMWB) || (state_q == S_BRANCH) ||
                       (state_q == S_JUMP) || (state_q == S_MEMWR && xfer);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        mdr_d   = mdr_q;
        rf_we   = 1'b0;
        rf_wa   = rt;
        rf_wd   = alu_q;
        case (state_q)
            S_FETCH: if (xfer) begin
                ir_d    = mem_rdata[31:0];
                pc_d    = pc_q + XLEN'(32'd4);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d   = rf_q[rs];
                b_d   = rf_q[rt];
                alu_d = pc_q + (imm_sext << 2);
                case (op)
                    OP_RTYPE:     state_d = funct_ok ? S_EXEC : S_HALT;
                    OP_ADDI:      state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_HALT;
                endcase
            end
            S_EXEC: begin
                alu_d   = (op == OP_RTYPE) ? r_res : a_q + imm_sext;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we   = 1'b1;
                rf_wa   = (op == OP_RTYPE) ? rd : rt;
                state_d = S_FETCH;
            end
            S_MEMADR: begin
                alu_d   = a_q + imm_sext;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: if (xfer) begin
                mdr_d   = mem_rdata;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                rf_we   = 1'b1;
                rf_wd   = mdr_q;
                state_d = S_FETCH;
            end
            S_MEMWR: if (xfer) state_d = S_FETCH;
            S_BRANCH: begin
                if (a_q == b_q) pc_d = alu_q;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_d    = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            // R0 is never written, so it always reads back as zero.
            if (rf_we && rf_wa != 5'd0) rf_q[rf_wa] <= rf_wd;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: trace tables of retired instructions with latency and
// next PC, a store scoreboard, wait-state memory model, halt/reset sequences and a 64-bit instance.
module tb_mips_multicycle_core;
    logic        clk, reset, rst64;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

    logic        mem_req64, mem_we64, retire64, halted64;
    logic [31:0] mem_addr64;
    logic [63:0] mem_wdata64, mem_rdata64, pc64;

    int n_chk, n_fail, wait_n, wcnt, cyc;
    bit need_pc, pend;
    logic [65:0] bus_prev;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        int          lat;
        logic [31:0] npc;
        bit          st;
        logic [31:0] sa;
        logic [31:0] sd;
    } vec_t;
    typedef struct { logic [31:0] a; logic [31:0] d; } st_t;

    vec_t        tv[$];
    st_t         exp_st[$];
    int          lat_obs[$];
    logic [31:0] npc_obs[$];
    logic [31:0] exp64_a[$];
    logic [63:0] exp64_d[$];

    logic [31:0] mem   [256];
    logic [63:0] mem64 [64];

    mips_multicycle_core u_dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
        .retire(retire), .halted(halted)
    );

    mips_multicycle_core #(.XLEN(64), .ADDR_W(32), .RESET_PC(64'h40)) u_dut64 (
        .clk(clk), .reset(rst64), .mem_req(mem_req64), .mem_we(mem_we64), .mem_addr(mem_addr64),
        .mem_wdata(mem_wdata64), .mem_rdata(mem_rdata64), .mem_ready(1'b1), .pc(pc64),
        .retire(retire64), .halted(halted64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: ready after wait_n stall cycles per transaction.
    assign mem_rdata   = mem[mem_addr[9:2]];
    assign mem_ready   = (wcnt >= wait_n);
    assign mem_rdata64 = mem64[mem_addr64[7:2]];

    always @(posedge clk or posedge reset) begin
        if (reset) wcnt <= 0;
        else if (mem_req && mem_ready) wcnt <= 0;
        else if (mem_req) wcnt <= wcnt + 1;
    end

    always @(posedge clk) begin
        if (!reset && mem_req && mem_we && mem_ready) mem[mem_addr[9:2]] = mem_wdata;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        st_t e;
        if (reset) begin
            cyc = 0; need_pc = 0; pend = 0;
        end else begin
            cyc++;
            if (need_pc) begin npc_obs.push_back(pc); need_pc = 0; end
            if (retire) begin lat_obs.push_back(cyc); cyc = 0; need_pc = 1; end
            if (pend) chk("req_hold", {mem_req, mem_we, mem_addr, mem_wdata}, bus_prev);
            pend     = mem_req && !mem_ready;
            bus_prev = {mem_req, mem_we, mem_addr, mem_wdata};
            if (mem_req && mem_we && mem_ready) begin
                if (exp_st.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL st_unexpected: got addr %0h data %0h want no store", mem_addr, mem_wdata);
                end else begin
                    e = exp_st.pop_front();
                    chk("st_addr", mem_addr, e.a);
                    chk("st_data", mem_wdata, e.d);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst64 && mem_req64 && mem_we64) begin
            if (exp64_a.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL x64_st_unexpected: got addr %0h want no store", mem_addr64);
            end else begin
                chk("x64_st_addr", mem_addr64, exp64_a.pop_front());
                chk("x64_st_data", mem_wdata64, exp64_d.pop_front());
            end
        end
    end

    function automatic logic [31:0] f_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction
    function automatic logic [31:0] f_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction
    function automatic logic [31:0] f_j(input logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction
    function automatic vec_t v(input logic [31:0] a, input logic [31:0] ins, input int lat,
                               input logic [31:0] npc, input bit st = 0,
                               input logic [31:0] sa = 0, input logic [31:0] sd = 0);
        vec_t r;
        r.addr = a; r.instr = ins; r.lat = lat; r.npc = npc; r.st = st; r.sa = sa; r.sd = sd;
        return r;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic run_trace(input int wn, input int budget);
        int c;
        reset = 1'b1;
        wait_n = wn;
        lat_obs.delete(); npc_obs.delete(); exp_st.delete();
        foreach (tv[i]) begin
            mem[tv[i].addr[9:2]] = tv[i].instr;
            if (tv[i].st) exp_st.push_back('{tv[i].sa, tv[i].sd});
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("first_fetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, tv[0].addr});
        c = 0;
        while (lat_obs.size() < tv.size() && c < budget) begin @(negedge clk); c++; end
        repeat (2) @(negedge clk);
        chk("retire_count", lat_obs.size() >= tv.size(), 1'b1);
        for (int i = 0; i < tv.size() && i < lat_obs.size(); i++) begin
            chk($sformatf("lat_%0d@%0h", i, tv[i].addr), lat_obs[i], tv[i].lat);
            if (i < npc_obs.size()) chk($sformatf("npc_%0d@%0h", i, tv[i].addr), npc_obs[i], tv[i].npc);
        end
        chk("stores_drained", exp_st.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c;
        n_chk = 0; n_fail = 0; wait_n = 0;
        reset = 1'b1; rst64 = 1'b1;
        clear_mem();
        for (int i = 0; i < 64; i++) mem64[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_state", {mem_req, retire, halted, pc}, {3'b000, 32'h0});

        // ALU ops, R0 write discard, branches both ways, jump, branch-to-self.
        tv.delete();
        tv.push_back(v(32'h000, f_i(6'h08, 0, 1, 16'd5),     4, 32'h004));
        tv.push_back(v(32'h004, f_i(6'h08, 0, 2, 16'hFFFD),  4, 32'h008));
        tv.push_back(v(32'h008, f_r(1, 2, 4, 6'h20),         4, 32'h00C));
        tv.push_back(v(32'h00C, f_r(1, 2, 5, 6'h22),         4, 32'h010));
        tv.push_back(v(32'h010, f_r(1, 2, 6, 6'h24),         4, 32'h014));
        tv.push_back(v(32'h014, f_r(1, 2, 7, 6'h25),         4, 32'h018));
        tv.push_back(v(32'h018, f_r(2, 1, 8, 6'h2A),         4, 32'h01C));
        tv.push_back(v(32'h01C, f_r(1, 2, 9, 6'h2A),         4, 32'h020));
        tv.push_back(v(32'h020, f_r(1, 1, 0, 6'h20),         4, 32'h024));
        tv.push_back(v(32'h024, f_i(6'h2B, 0, 4, 16'h200),   4, 32'h028, 1, 32'h200, 32'd2));
        tv.push_back(v(32'h028, f_i(6'h2B, 0, 5, 16'h204),   4, 32'h02C, 1, 32'h204, 32'd8));
        tv.push_back(v(32'h02C, f_i(6'h2B, 0, 6, 16'h208),   4, 32'h030, 1, 32'h208, 32'd5));
        tv.push_back(v(32'h030, f_i(6'h2B, 0, 7, 16'h20C),   4, 32'h034, 1, 32'h20C, 32'hFFFF_FFFD));
        tv.push_back(v(32'h034, f_i(6'h2B, 0, 8, 16'h210),   4, 32'h038, 1, 32'h210, 32'd1));
        tv.push_back(v(32'h038, f_i(6'h2B, 0, 9, 16'h214),   4, 32'h03C, 1, 32'h214, 32'd0));
        tv.push_back(v(32'h03C, f_i(6'h2B, 0, 0, 16'h218),   4, 32'h040, 1, 32'h218, 32'd0));
        tv.push_back(v(32'h040, f_i(6'h04, 1, 2, 16'd5),     3, 32'h044));
        tv.push_back(v(32'h044, f_i(6'h04, 1, 1, 16'd1),     3, 32'h04C));
        tv.push_back(v(32'h04C, f_j(26'h40),                 3, 32'h100));
        tv.push_back(v(32'h100, f_i(6'h2B, 0, 10, 16'h21C),  4, 32'h104, 1, 32'h21C, 32'd0));
        tv.push_back(v(32'h104, f_i(6'h2B, 0, 1, 16'h220),   4, 32'h108, 1, 32'h220, 32'd5));
        tv.push_back(v(32'h108, f_i(6'h04, 0, 0, 16'hFFFF),  3, 32'h108));
        tv.push_back(v(32'h108, f_i(6'h04, 0, 0, 16'hFFFF),  3, 32'h108));
        clear_mem();
        mem[18] = f_i(6'h08, 0, 10, 16'd1);  // at 0x48, skipped by the taken branch
        run_trace(0, 400);

        // Store then load with 3 wait states per memory access.
        tv.delete();
        tv.push_back(v(32'h000, f_j(26'h10),                 6, 32'h040));
        tv.push_back(v(32'h040, f_i(6'h08, 0, 1, 16'd5),     7, 32'h044));
        tv.push_back(v(32'h044, f_i(6'h2B, 0, 1, 16'd8),    10, 32'h048, 1, 32'h008, 32'd5));
        tv.push_back(v(32'h048, f_i(6'h23, 0, 3, 16'd8),    11, 32'h04C));
        tv.push_back(v(32'h04C, f_i(6'h2B, 0, 3, 16'h200),  10, 32'h050, 1, 32'h200, 32'd5));
        clear_mem();
        run_trace(3, 400);

        // Reset while a fetch is stalled drops the request immediately.
        reset = 1'b1; clear_mem(); wait_n = 3;
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("midtx_pending", {mem_req, mem_ready}, 2'b10);
        reset = 1'b1; #1;
        chk("midtx_drop", mem_req, 1'b0);

        // Illegal opcode halts after DECODE and stays idle until reset.
        wait_n = 0; clear_mem(); mem[0] = 32'hFC00_0000; lat_obs.delete();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); chk("halt_c1", halted, 1'b0);
        @(negedge clk); chk("halt_c2", halted, 1'b0);
        @(negedge clk); chk("halt_c3", halted, 1'b1);
        repeat (20) begin @(negedge clk); chk("halt_idle", {halted, mem_req, retire}, 3'b100); end
        chk("halt_no_retire", lat_obs.size(), 0);
        reset = 1'b1; #1;
        chk("halt_rst_clear", {halted, mem_req}, 2'b00);

        // Illegal R-type funct halts too; restart fetches from RESET_PC.
        mem[0] = f_r(1, 2, 3, 6'h21); lat_obs.delete();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); chk("restart_fetch", {mem_req, mem_addr}, {1'b1, 32'h0});
        repeat (2) @(negedge clk);
        chk("funct_halt", {halted, mem_req}, 2'b10);
        chk("funct_no_retire", lat_obs.size(), 0);
        reset = 1'b1;

        // 64-bit datapath: sign-extended immediate and wrap-around.
        mem64[16] = 64'(f_i(6'h08, 0, 1, 16'hFFFF));
        mem64[17] = 64'(f_i(6'h2B, 0, 1, 16'h80));
        mem64[18] = 64'(f_i(6'h08, 1, 2, 16'd1));
        mem64[19] = 64'(f_i(6'h2B, 0, 2, 16'h88));
        exp64_a.push_back(32'h80); exp64_d.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        exp64_a.push_back(32'h88); exp64_d.push_back(64'h0);
        @(posedge clk); #1 rst64 = 1'b0;
        @(negedge clk);
        chk("x64_first_fetch", {mem_req64, mem_addr64}, {1'b1, 32'h40});
        c = 0;
        while (!(halted64 && exp64_a.size() == 0) && c < 100) begin @(negedge clk); c++; end
        chk("x64_done", {halted64, exp64_a.size() == 0}, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
